// File: rtl/c432_key_pkg.sv
// Shared types and constants for the c432 key loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c432_key_pkg;

    localparam int KEY_W  = 32;
    localparam int BEAT_W = 4;
    localparam int NBEATS = KEY_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [CNT_W-1:0] beat_cnt_t;

    // Even parity over the assembled key: the parity beat must carry this value.
    function automatic logic key_parity(input logic [KEY_W-1:0] k);
        return ^k;
    endfunction

endpackage

// File: rtl/c432_key_loader.sv
// Collects a 32-bit unlock key in 4-bit beats and commits it atomically onto key[]; optional parity beat when KEY_PARITY_EN is defined.
// Latency: key/key_valid appear one cycle after the last accepted beat (the parity beat if KEY_PARITY_EN is defined).
// Backpressure: sdata_ready is registered, high only while receiving; gaps on sdata_valid stall without losing state.
module c432_key_loader
    import c432_key_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [BEAT_W-1:0] sdata,
    input  logic              sdata_valid,
    output logic              sdata_ready,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    output logic              busy,
    output logic              err
);

    state_t           state;
    beat_cnt_t        cnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nxt;
    logic             beat_xfer;
    logic             last_beat;

`ifdef KEY_PARITY_EN
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign beat_xfer = sdata_valid && sdata_ready;
    assign last_beat = (cnt == beat_cnt_t'(NBEATS - 1));

    // Shadow with the current beat merged in, so the last data beat can be committed on its own edge.
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[cnt*BEAT_W +: BEAT_W] = sdata;
    end

    // Load sequencer: beat collection, optional parity check, one-time commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            key         <= '0;
            key_valid   <= 1'b0;
            busy        <= 1'b0;
            sdata_ready <= 1'b0;
`ifdef KEY_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state       <= RECV;
                        cnt         <= '0;
                        shadow      <= '0;
                        busy        <= 1'b1;
                        sdata_ready <= 1'b1;
`ifdef KEY_PARITY_EN
                        err_q       <= 1'b0;
`endif
                    end
                end

                RECV: begin
                    if (beat_xfer) begin
                        shadow <= shadow_nxt;
                        if (last_beat) begin
                            cnt <= '0;
`ifdef KEY_PARITY_EN
                            // Stay ready: one more beat carries the parity bit.
                            state <= PAR;
`else
                            state       <= DONE;
                            key         <= shadow_nxt;
                            key_valid   <= 1'b1;
                            busy        <= 1'b0;
                            sdata_ready <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                PAR: begin
`ifdef KEY_PARITY_EN
                    if (beat_xfer) begin
                        busy        <= 1'b0;
                        sdata_ready <= 1'b0;
                        if (sdata[0] == key_parity(shadow)) begin
                            state     <= DONE;
                            key       <= shadow;
                            key_valid <= 1'b1;
                        end else begin
                            // Failed load leaves key untouched so a retry is possible.
                            state <= IDLE;
                            err_q <= 1'b1;
                        end
                    end
`else
                    state       <= IDLE;
                    busy        <= 1'b0;
                    sdata_ready <= 1'b0;
`endif
                end

                DONE: begin
                    // One-time load: only reset leaves this state.
                    state       <= DONE;
                    busy        <= 1'b0;
                    sdata_ready <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    sdata_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed self-checking bench for c432_key_loader (default build; parity test when KEY_PARITY_EN is defined).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: beat driver waits (bounded) for sdata_ready before presenting a beat.
module tb_c432_key_loader;
    import c432_key_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [BEAT_W-1:0] sdata;
    logic              sdata_valid;
    logic              sdata_ready;
    logic [KEY_W-1:0]  key;
    logic              key_valid;
    logic              busy;
    logic              err;

    int n_chk  = 0;
    int n_pass = 0;

    c432_key_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .sdata       (sdata),
        .sdata_valid (sdata_valid),
        .sdata_ready (sdata_ready),
        .key         (key),
        .key_valid   (key_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present one beat; wait (bounded) for ready first.
    task automatic send_beat(input logic [BEAT_W-1:0] d);
        int waited = 0;
        while (!sdata_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!sdata_ready) chk("ready_timeout", 32'd0, 32'd1);
        sdata       = d;
        sdata_valid = 1'b1;
        tick();
        sdata_valid = 1'b0;
    endtask

    // Send data beats lo..hi of key k, least-significant nibble first.
    task automatic send_beats(input logic [KEY_W-1:0] k, input int lo, input int hi);
        logic [KEY_W-1:0] kk;
        kk = k;
        for (int i = lo; i <= hi; i++) send_beat(kk[i*BEAT_W +: BEAT_W]);
    endtask

    // Close the load: with parity enabled, append the correct even-parity beat.
    task automatic finish_load(input logic [KEY_W-1:0] k);
`ifdef KEY_PARITY_EN
        send_beat({3'b000, ^k});
`else
        chk("pre_commit_valid", 32'(key_valid), 32'd1);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        load_start  = 1'b0;
        sdata       = '0;
        sdata_valid = 1'b0;

        // Reset state
        do_reset();
        chk("rst_key",       key,                 32'h0);
        chk("rst_key_valid", 32'(key_valid),      32'd0);
        chk("rst_busy",      32'(busy),           32'd0);
        chk("rst_err",       32'(err),            32'd0);
        chk("rst_ready",     32'(sdata_ready),    32'd0);

        // T1: back-to-back beats of 0xA5C30F96
        pulse_start();
        chk("t1_busy",  32'(busy),        32'd1);
        chk("t1_ready", 32'(sdata_ready), 32'd1);
        send_beats(32'hA5C30F96, 0, 6);
        chk("t1_no_early_valid", 32'(key_valid), 32'd0);
        chk("t1_no_early_key",   key,            32'h0);
        send_beats(32'hA5C30F96, 7, 7);
        finish_load(32'hA5C30F96);
        chk("t1_key",       key,                 32'hA5C30F96);
        chk("t1_key_valid", 32'(key_valid),      32'd1);
        chk("t1_busy_off",  32'(busy),           32'd0);
        chk("t1_ready_off", 32'(sdata_ready),    32'd0);

        // T4: DONE is terminal
        pulse_start();
        sdata = 4'h3;
        sdata_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_ready", 32'(sdata_ready), 32'd0);
        end
        sdata_valid = 1'b0;
        chk("t4_key",       key,            32'hA5C30F96);
        chk("t4_key_valid", 32'(key_valid), 32'd1);
        chk("t4_busy",      32'(busy),      32'd0);

        // T3: reset mid-load, then full reload of 0x12345678
        do_reset();
        pulse_start();
        send_beats(32'h12345678, 0, 2);
        do_reset();
        chk("t3_abort_busy",  32'(busy),        32'd0);
        chk("t3_abort_ready", 32'(sdata_ready), 32'd0);
        chk("t3_abort_key",   key,              32'h0);
        pulse_start();
        send_beats(32'hDEADBEEF, 0, 0);
        do_reset();
        pulse_start();
        send_beats(32'h12345678, 0, 7);
        finish_load(32'h12345678);
        chk("t3_key",       key,            32'h12345678);
        chk("t3_key_valid", 32'(key_valid), 32'd1);

        // T2: stalls between beats 2/3 and 5/6
        do_reset();
        pulse_start();
        send_beats(32'hA5C30F96, 0, 2);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_gap1_busy", 32'(busy),      32'd1);
        chk("t2_gap1_kv",   32'(key_valid), 32'd0);
        send_beats(32'hA5C30F96, 3, 5);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_gap2_ready", 32'(sdata_ready), 32'd1);
        send_beats(32'hA5C30F96, 6, 7);
        finish_load(32'hA5C30F96);
        chk("t2_key",       key,            32'hA5C30F96);
        chk("t2_key_valid", 32'(key_valid), 32'd1);

        // T6: load_start while busy is ignored
        do_reset();
        pulse_start();
        send_beats(32'h0F1E2D3C, 0, 3);
        pulse_start();
        chk("t6_busy", 32'(busy), 32'd1);
        send_beats(32'h0F1E2D3C, 4, 6);
        chk("t6_no_early_valid", 32'(key_valid), 32'd0);
        send_beats(32'h0F1E2D3C, 7, 7);
        finish_load(32'h0F1E2D3C);
        chk("t6_key",       key,            32'h0F1E2D3C);
        chk("t6_key_valid", 32'(key_valid), 32'd1);

        // rst and load_start together: reset wins
        load_start = 1'b1;
        rst = 1'b1;
        tick();
        load_start = 1'b0;
        rst = 1'b0;
        chk("rst_wins_busy", 32'(busy),      32'd0);
        chk("rst_wins_kv",   32'(key_valid), 32'd0);

`ifdef KEY_PARITY_EN
        // T5: bad parity, then a good retry
        do_reset();
        pulse_start();
        send_beats(32'hA5C30F96, 0, 7);
        chk("t5_par_ready", 32'(sdata_ready), 32'd1);
        send_beat(4'h1);
        chk("t5_err",       32'(err),       32'd1);
        chk("t5_key",       key,            32'h0);
        chk("t5_key_valid", 32'(key_valid), 32'd0);
        chk("t5_busy",      32'(busy),      32'd0);
        pulse_start();
        chk("t5_err_clr", 32'(err), 32'd0);
        send_beats(32'hA5C30F96, 0, 7);
        send_beat(4'hE);
        chk("t5_retry_key", key,            32'hA5C30F96);
        chk("t5_retry_kv",  32'(key_valid), 32'd1);
        chk("t5_retry_err", 32'(err),       32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
